// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-state and hazard-control bundle exchanged between
//               the 5-stage datapath (master) and the hazard unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int RW = 5
);
  // D stage
  logic [RW-1:0] rsD;
  logic [RW-1:0] rtD;
  logic          branchD;
  // E stage
  logic [RW-1:0] rsE;
  logic [RW-1:0] rtE;
  logic [RW-1:0] writeregE;
  logic          regwriteE;
  logic          memtoregE;
  logic          cp0_to_regE;
  logic [1:0]    hilo_readE;
  logic          div_startE;
  // M stage
  logic [RW-1:0] writeregM;
  logic          regwriteM;
  logic          memtoregM;
  logic [1:0]    hilo_writeM;
  logic [31:0]   excepttypeM;
  logic [31:0]   cp0_epcM;
  // W stage
  logic [RW-1:0] writeregW;
  logic          regwriteW;
  logic [1:0]    hilo_writeW;
  // memory wait requests
  logic          imem_stall;
  logic          dmem_stall;
  // forwarding selects
  logic [1:0]    forwardaD;
  logic [1:0]    forwardbD;
  logic [1:0]    forwardaE;
  logic [1:0]    forwardbE;
  logic [1:0]    forward_hiloE;
  // stage holds and bubbles
  logic          stallF;
  logic          stallD;
  logic          stallE;
  logic          stallM;
  logic          stallW;
  logic          flushD;
  logic          flushE;
  logic          flushM;
  logic          flushW;
  // divider and redirect control
  logic          div_busy;
  logic          div_cancel;
  logic          pc_redirect;
  logic [31:0]   newpc;

  // datapath side
  modport master (
    output rsD, rtD, branchD,
    output rsE, rtE, writeregE, regwriteE, memtoregE, cp0_to_regE,
    output hilo_readE, div_startE,
    output writeregM, regwriteM, memtoregM, hilo_writeM, excepttypeM, cp0_epcM,
    output writeregW, regwriteW, hilo_writeW,
    output imem_stall, dmem_stall,
    input  forwardaD, forwardbD, forwardaE, forwardbE, forward_hiloE,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushD, flushE, flushM, flushW,
    input  div_busy, div_cancel, pc_redirect, newpc
  );

  // hazard unit side
  modport slave (
    input  rsD, rtD, branchD,
    input  rsE, rtE, writeregE, regwriteE, memtoregE, cp0_to_regE,
    input  hilo_readE, div_startE,
    input  writeregM, regwriteM, memtoregM, hilo_writeM, excepttypeM, cp0_epcM,
    input  writeregW, regwriteW, hilo_writeW,
    input  imem_stall, dmem_stall,
    output forwardaD, forwardbD, forwardaE, forwardbE, forward_hiloE,
    output stallF, stallD, stallE, stallM, stallW,
    output flushD, flushE, flushM, flushW,
    output div_busy, div_cancel, pc_redirect, newpc
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard unit for the 5-stage MIPS pipeline. Produces GPR and
//               HI/LO forwarding selects, prioritised stall/flush controls,
//               a cycle-counted divider stall and a registered exception
//               redirect (newpc / pc_redirect).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int          RW        = 5,
  parameter int          DIV_LAT   = 34,
  parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
  parameter logic [31:0] ERET_CODE = 32'h0000_000E
) (
  input  wire logic     clk,
  input  wire logic     resetn,
  hazard_ctrl_if.slave  hz
);

  // Counter only has to hold DIV_LAT-1, which always fits in clog2(DIV_LAT) bits.
  localparam int                 c_cnt_w    = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DIV_LAT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DIV   = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_newpc;
  logic               r_pc_redirect;

  logic       w_exc;
  logic       w_div_start;
  logic       w_div_active;
  logic       w_ldstall;
  logic       w_brstall;
  logic       w_ldbr;
  logic       w_br_e_hit;
  logic       w_br_m_hit;
  logic [1:0] w_fwd_a_d;
  logic [1:0] w_fwd_b_d;
  logic [1:0] w_fwd_a_e;
  logic [1:0] w_fwd_b_e;
  logic [1:0] w_fwd_hilo;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_stall_w;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_flush_m;
  logic       w_flush_w;
  logic       w_div_cancel;

  // D-stage operand source: E beats M beats W; register 0 is never forwarded.
  function automatic logic [1:0] fwd_d(
    input logic [RW-1:0] src,
    input logic          we_e, input logic [RW-1:0] wr_e,
    input logic          we_m, input logic [RW-1:0] wr_m,
    input logic          we_w, input logic [RW-1:0] wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (we_e && (wr_e == src))      sel = 2'b01;
      else if (we_m && (wr_m == src)) sel = 2'b10;
      else if (we_w && (wr_w == src)) sel = 2'b11;
    end
    return sel;
  endfunction

  // E-stage operand source: M (10) beats W (01).
  function automatic logic [1:0] fwd_e(
    input logic [RW-1:0] src,
    input logic          we_m, input logic [RW-1:0] wr_m,
    input logic          we_w, input logic [RW-1:0] wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (we_m && (wr_m == src))      sel = 2'b10;
      else if (we_w && (wr_w == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Forwarding selects for GPR operands and HI/LO reads.
  always_comb begin
    w_fwd_a_d = fwd_d(hz.rsD, hz.regwriteE, hz.writeregE, hz.regwriteM, hz.writeregM,
                      hz.regwriteW, hz.writeregW);
    w_fwd_b_d = fwd_d(hz.rtD, hz.regwriteE, hz.writeregE, hz.regwriteM, hz.writeregM,
                      hz.regwriteW, hz.writeregW);
    w_fwd_a_e = fwd_e(hz.rsE, hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW);
    w_fwd_b_e = fwd_e(hz.rtE, hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW);
    // Only the half (HI or LO) actually read in E matters for the match.
    w_fwd_hilo = 2'b00;
    if ((hz.hilo_readE & hz.hilo_writeM) != 2'b00)      w_fwd_hilo = 2'b01;
    else if ((hz.hilo_readE & hz.hilo_writeW) != 2'b00) w_fwd_hilo = 2'b10;
  end

  // Hazard detection and stall-source qualification.
  always_comb begin
    w_ldstall  = ((hz.rsD == hz.rtE) || (hz.rtD == hz.rtE)) && (hz.rtE != '0) &&
                 (hz.memtoregE || hz.cp0_to_regE);
    w_br_e_hit = hz.regwriteE && (hz.writeregE != '0) &&
                 ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
    w_br_m_hit = hz.memtoregM && (hz.writeregM != '0) &&
                 ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD));
    w_brstall  = hz.branchD && (w_br_e_hit || w_br_m_hit);
    w_ldbr     = w_ldstall || w_brstall;
    // M is already flushed while redirecting, so its exception code is stale.
    w_exc       = (hz.excepttypeM != 32'h0) && (r_state != REDIR);
    w_div_start = (r_state == RUN) && hz.div_startE && !w_exc && !hz.dmem_stall;
    w_div_active = (r_state == DIV) || w_div_start;
  end

  // Prioritised stall/flush selection; everything quiet while in reset.
  always_comb begin
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_stall_m    = 1'b0;
    w_stall_w    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_flush_m    = 1'b0;
    w_flush_w    = 1'b0;
    w_div_cancel = 1'b0;
    if (resetn) begin
      if (w_exc) begin
        w_flush_d    = 1'b1;
        w_flush_e    = 1'b1;
        w_flush_m    = 1'b1;
        w_div_cancel = (r_state == DIV);
      end else if (hz.dmem_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
      end else if (w_div_active) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_flush_m = 1'b1;
      end else if (hz.imem_stall) begin
        w_stall_f = 1'b1;
        // A concurrent load/branch hazard holds D, so the bubble moves to E.
        if (w_ldbr) begin
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end else begin
          w_flush_d = 1'b1;
        end
      end else if (w_ldbr) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
      // The instruction fetched on the old path must not enter D.
      if (r_state == REDIR) w_flush_d = 1'b1;
    end
  end

  // Control FSM: divider occupancy counter and exception redirect target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_newpc       <= 32'h0;
      r_pc_redirect <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_exc) begin
            r_state       <= REDIR;
            r_pc_redirect <= 1'b1;
            r_newpc       <= (hz.excepttypeM == ERET_CODE) ? hz.cp0_epcM : EXC_VEC;
          end else if (w_div_start) begin
            r_state <= DIV;
            r_cnt   <= c_cnt_load;
          end
        end
        DIV: begin
          if (w_exc) begin
            r_state       <= REDIR;
            r_cnt         <= '0;
            r_pc_redirect <= 1'b1;
            r_newpc       <= (hz.excepttypeM == ERET_CODE) ? hz.cp0_epcM : EXC_VEC;
          end else if (!hz.dmem_stall) begin
            if (r_cnt == c_cnt_one) begin
              r_state <= RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
        end
        REDIR: begin
          if (!hz.imem_stall) begin
            r_state       <= RUN;
            r_pc_redirect <= 1'b0;
          end
        end
        default: begin
          r_state       <= RUN;
          r_cnt         <= '0;
          r_pc_redirect <= 1'b0;
        end
      endcase
    end
  end

  assign hz.forwardaD     = w_fwd_a_d;
  assign hz.forwardbD     = w_fwd_b_d;
  assign hz.forwardaE     = w_fwd_a_e;
  assign hz.forwardbE     = w_fwd_b_e;
  assign hz.forward_hiloE = w_fwd_hilo;
  assign hz.stallF        = w_stall_f;
  assign hz.stallD        = w_stall_d;
  assign hz.stallE        = w_stall_e;
  assign hz.stallM        = w_stall_m;
  assign hz.stallW        = w_stall_w;
  assign hz.flushD        = w_flush_d;
  assign hz.flushE        = w_flush_e;
  assign hz.flushM        = w_flush_m;
  assign hz.flushW        = w_flush_w;
  assign hz.div_busy      = resetn && w_div_active;
  assign hz.div_cancel    = w_div_cancel;
  assign hz.pc_redirect   = r_pc_redirect;
  assign hz.newpc         = r_newpc;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (DIV_LAT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  hazard_ctrl_if #(.RW(5)) hif ();

  hazard_ctrl #(
    .RW       (5),
    .DIV_LAT  (4),
    .EXC_VEC  (32'hBFC0_0380),
    .ERET_CODE(32'h0000_000E)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.rsD = '0; hif.rtD = '0; hif.branchD = 1'b0;
    hif.rsE = '0; hif.rtE = '0; hif.writeregE = '0;
    hif.regwriteE = 1'b0; hif.memtoregE = 1'b0; hif.cp0_to_regE = 1'b0;
    hif.hilo_readE = 2'b00; hif.div_startE = 1'b0;
    hif.writeregM = '0; hif.regwriteM = 1'b0; hif.memtoregM = 1'b0;
    hif.hilo_writeM = 2'b00; hif.excepttypeM = 32'h0; hif.cp0_epcM = 32'h0;
    hif.writeregW = '0; hif.regwriteW = 1'b0; hif.hilo_writeW = 2'b00;
    hif.imem_stall = 1'b0; hif.dmem_stall = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] ctl;
    resetn = 1'b0;
    clear_inputs();
    hif.dmem_stall = 1'b1;
    hif.div_startE = 1'b1;
    #3;
    ctl = {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.stallW,
           hif.flushD, hif.flushE, hif.flushM, hif.flushW, hif.div_cancel};
    n_cmp++;
    if (ctl !== 10'b0) begin
      $display("FAIL reset_ctl: got %b expected %b", ctl, 10'b0); n_bad++;
    end
    n_cmp++;
    if ({hif.pc_redirect, hif.div_busy, hif.newpc} !== 34'h0) begin
      $display("FAIL reset_regs: redirect=%b busy=%b newpc=%h expected 0/0/0",
               hif.pc_redirect, hif.div_busy, hif.newpc); n_bad++;
    end
    step();
    step();
    clear_inputs();
    resetn = 1'b1;
    #2;
  endtask

  task automatic test_forward_d();
    clear_inputs();
    hif.writeregE = 5'd5; hif.regwriteE = 1'b1;
    hif.writeregM = 5'd5; hif.regwriteM = 1'b1;
    hif.rsD = 5'd5; hif.rtD = 5'd5;
    #2;
    n_cmp++;
    if ({hif.forwardaD, hif.forwardbD} !== 4'b0101) begin
      $display("FAIL fwdD_E: got %b expected 0101", {hif.forwardaD, hif.forwardbD}); n_bad++;
    end
    hif.regwriteE = 1'b0;
    #2;
    n_cmp++;
    if (hif.forwardaD !== 2'b10) begin
      $display("FAIL fwdD_M: got %b expected 10", hif.forwardaD); n_bad++;
    end
    hif.regwriteM = 1'b0; hif.writeregW = 5'd5; hif.regwriteW = 1'b1;
    #2;
    n_cmp++;
    if (hif.forwardaD !== 2'b11) begin
      $display("FAIL fwdD_W: got %b expected 11", hif.forwardaD); n_bad++;
    end
    clear_inputs();
    hif.rsD = 5'd0; hif.writeregE = 5'd0; hif.regwriteE = 1'b1;
    #2;
    n_cmp++;
    if (hif.forwardaD !== 2'b00) begin
      $display("FAIL fwdD_zero: got %b expected 00", hif.forwardaD); n_bad++;
    end
  endtask

  task automatic test_forward_e();
    clear_inputs();
    hif.rsE = 5'd7; hif.rtE = 5'd9;
    hif.writeregM = 5'd7; hif.regwriteM = 1'b1;
    hif.writeregW = 5'd9; hif.regwriteW = 1'b1;
    #2;
    n_cmp++;
    if ({hif.forwardaE, hif.forwardbE} !== 4'b1001) begin
      $display("FAIL fwdE_MW: got %b expected 1001", {hif.forwardaE, hif.forwardbE}); n_bad++;
    end
    hif.writeregW = 5'd7;
    hif.regwriteM = 1'b0;
    #2;
    n_cmp++;
    if ({hif.forwardaE, hif.forwardbE} !== 4'b0100) begin
      $display("FAIL fwdE_W: got %b expected 0100", {hif.forwardaE, hif.forwardbE}); n_bad++;
    end
  endtask

  task automatic test_hilo();
    clear_inputs();
    hif.hilo_readE = 2'b10; hif.hilo_writeM = 2'b01; hif.hilo_writeW = 2'b10;
    #2;
    n_cmp++;
    if (hif.forward_hiloE !== 2'b10) begin
      $display("FAIL hilo_W: got %b expected 10", hif.forward_hiloE); n_bad++;
    end
    hif.hilo_writeM = 2'b11;
    #2;
    n_cmp++;
    if (hif.forward_hiloE !== 2'b01) begin
      $display("FAIL hilo_M: got %b expected 01", hif.forward_hiloE); n_bad++;
    end
    hif.hilo_readE = 2'b00;
    #2;
    n_cmp++;
    if (hif.forward_hiloE !== 2'b00) begin
      $display("FAIL hilo_none: got %b expected 00", hif.forward_hiloE); n_bad++;
    end
  endtask

  task automatic test_ld_br_stall();
    clear_inputs();
    hif.memtoregE = 1'b1; hif.rtE = 5'd8; hif.rsD = 5'd8;
    #2;
    n_cmp++;
    if ({hif.stallF, hif.stallD, hif.flushE, hif.flushD} !== 4'b1110) begin
      $display("FAIL ldstall: got %b expected 1110",
               {hif.stallF, hif.stallD, hif.flushE, hif.flushD}); n_bad++;
    end
    hif.rtE = 5'd0; hif.rsD = 5'd0;
    #2;
    n_cmp++;
    if ({hif.stallF, hif.stallD, hif.flushE} !== 3'b000) begin
      $display("FAIL ldstall_r0: got %b expected 000",
               {hif.stallF, hif.stallD, hif.flushE}); n_bad++;
    end
    clear_inputs();
    hif.branchD = 1'b1; hif.rtD = 5'd9; hif.regwriteE = 1'b1; hif.writeregE = 5'd9;
    #2;
    n_cmp++;
    if ({hif.stallF, hif.stallD, hif.flushE} !== 3'b111) begin
      $display("FAIL brstall: got %b expected 111",
               {hif.stallF, hif.stallD, hif.flushE}); n_bad++;
    end
    hif.branchD = 1'b0;
    #2;
    n_cmp++;
    if ({hif.stallF, hif.stallD, hif.flushE} !== 3'b000) begin
      $display("FAIL brstall_nobr: got %b expected 000",
               {hif.stallF, hif.stallD, hif.flushE}); n_bad++;
    end
  endtask

  task automatic test_mem_stall();
    clear_inputs();
    hif.imem_stall = 1'b1;
    #2;
    n_cmp++;
    if ({hif.stallF, hif.stallD, hif.flushD, hif.flushE} !== 4'b1010) begin
      $display("FAIL imem: got %b expected 1010",
               {hif.stallF, hif.stallD, hif.flushD, hif.flushE}); n_bad++;
    end
    hif.memtoregE = 1'b1; hif.rtE = 5'd3; hif.rtD = 5'd3;
    #2;
    n_cmp++;
    if ({hif.stallF, hif.stallD, hif.flushD, hif.flushE} !== 4'b1101) begin
      $display("FAIL imem_ld: got %b expected 1101",
               {hif.stallF, hif.stallD, hif.flushD, hif.flushE}); n_bad++;
    end
    clear_inputs();
    hif.dmem_stall = 1'b1; hif.imem_stall = 1'b1;
    #2;
    n_cmp++;
    if ({hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushW, hif.flushD}
        !== 6'b111110) begin
      $display("FAIL dmem: got %b expected 111110",
               {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushW, hif.flushD});
      n_bad++;
    end
    clear_inputs();
  endtask

  // Counts stallE-high cycles starting at the divide's start cycle.
  task automatic test_div(input logic with_dmem);
    int hi;
    clear_inputs();
    step();
    hif.div_startE = 1'b1;
    #2;
    n_cmp++;
    if ({hif.div_busy, hif.stallE, hif.flushM} !== 3'b111) begin
      $display("FAIL div_start: dmem=%0b got %b expected 111", with_dmem,
               {hif.div_busy, hif.stallE, hif.flushM}); n_bad++;
    end
    hi = hif.stallE ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      step();
      hif.div_startE = 1'b0;
      hif.dmem_stall = with_dmem && (i == 2 || i == 3);
      #2;
      if (hif.stallE) hi++;
    end
    n_cmp++;
    if (hi !== (with_dmem ? 6 : 4)) begin
      $display("FAIL div_len: dmem=%0b got %0d cycles expected %0d", with_dmem, hi,
               with_dmem ? 6 : 4); n_bad++;
    end
    clear_inputs();
  endtask

  task automatic test_exc_in_div();
    clear_inputs();
    step();
    hif.div_startE = 1'b1;
    step();
    hif.div_startE = 1'b0;
    step();
    hif.excepttypeM = 32'h1;
    #2;
    n_cmp++;
    if ({hif.div_cancel, hif.flushD, hif.flushE, hif.flushM, hif.stallE} !== 5'b11110) begin
      $display("FAIL exc_div: got %b expected 11110",
               {hif.div_cancel, hif.flushD, hif.flushE, hif.flushM, hif.stallE}); n_bad++;
    end
    step();
    hif.excepttypeM = 32'h0;
    #2;
    n_cmp++;
    if ({hif.pc_redirect, hif.flushD, hif.div_cancel} !== 3'b110 ||
        hif.newpc !== 32'hBFC0_0380) begin
      $display("FAIL exc_redir: redirect/flushD/cancel=%b newpc=%h expected 110 bfc00380",
               {hif.pc_redirect, hif.flushD, hif.div_cancel}, hif.newpc); n_bad++;
    end
    step();
    #2;
    n_cmp++;
    if ({hif.pc_redirect, hif.div_busy, hif.stallE} !== 3'b000) begin
      $display("FAIL exc_run: got %b expected 000",
               {hif.pc_redirect, hif.div_busy, hif.stallE}); n_bad++;
    end
  endtask

  task automatic test_eret();
    int hi;
    clear_inputs();
    hif.excepttypeM = 32'h0000_000E; hif.cp0_epcM = 32'h8000_1234;
    hi = 0;
    for (int i = 1; i < 9; i++) begin
      step();
      hif.excepttypeM = 32'h0;
      hif.imem_stall = (i <= 3);
      #2;
      if (hif.pc_redirect) hi++;
      if (i == 1) begin
        n_cmp++;
        if (hif.newpc !== 32'h8000_1234) begin
          $display("FAIL eret_newpc: got %h expected 80001234", hif.newpc); n_bad++;
        end
      end
    end
    n_cmp++;
    if (hi !== 4) begin
      $display("FAIL eret_hold: got %0d cycles expected 4", hi); n_bad++;
    end
    n_cmp++;
    if ({hif.pc_redirect, hif.flushD} !== 2'b00) begin
      $display("FAIL eret_run: got %b expected 00", {hif.pc_redirect, hif.flushD}); n_bad++;
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    hif.excepttypeM = 32'h5;
    step();
    hif.excepttypeM = 32'h0;
    hif.imem_stall = 1'b1;
    #2;
    n_cmp++;
    if (hif.pc_redirect !== 1'b1) begin
      $display("FAIL areset_pre: got %b expected 1", hif.pc_redirect); n_bad++;
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({hif.pc_redirect, hif.flushD} !== 2'b00 || hif.newpc !== 32'h0) begin
      $display("FAIL areset_redir: redirect/flushD=%b newpc=%h expected 00 00000000",
               {hif.pc_redirect, hif.flushD}, hif.newpc); n_bad++;
    end
    step();
    clear_inputs();
    resetn = 1'b1;
    step();
    hif.div_startE = 1'b1;
    step();
    hif.div_startE = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({hif.div_busy, hif.div_cancel, hif.stallE} !== 3'b000) begin
      $display("FAIL areset_div: got %b expected 000",
               {hif.div_busy, hif.div_cancel, hif.stallE}); n_bad++;
    end
    step();
    resetn = 1'b1;
    #2;
    n_cmp++;
    if ({hif.div_busy, hif.stallE} !== 2'b00) begin
      $display("FAIL areset_run: got %b expected 00", {hif.div_busy, hif.stallE}); n_bad++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b0;
    test_reset();
    test_forward_d();
    test_forward_e();
    test_hilo();
    test_ld_br_stall();
    test_mem_stall();
    test_div(1'b0);
    test_div(1'b1);
    test_exc_in_div();
    test_eret();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised successor to the single-cycle combinational MIPS hazard unit. Covers:
- GPR and HI/LO forwarding and load/CP0-use stalls.
- A cycle-counted multi-cycle divider stall, so the divider no longer drives the stall itself.
- I/D memory wait stalls.
- A registered exception-redirect FSM.
Sits beside the 5-stage datapath and drives all stall/flush/forward selects.

Parameters:
RW, 5, register-specifier width (2^RW registers, index 0 hard-wired zero)
DIV_LAT, 34, cycles a divide occupies E (>=2)
EXC_VEC, 32'hBFC00380, general exception entry address
ERET_CODE, 32'h0000000E, excepttypeM value meaning ERET (redirect to EPC)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
rsD, rtD  in  RW  D-stage source specifiers
branchD  in  1  D-stage branch/jr needs operands
rsE, rtE, writeregE  in  RW  E-stage specifiers
regwriteE, memtoregE, cp0_to_regE  in  1  E-stage write/load/mfc0 flags
writeregM  in  RW;  regwriteM, memtoregM  in  1  M-stage info
writeregW  in  RW;  regwriteW  in  1  W-stage info
hilo_readE  in  2  [1]=mfhi, [0]=mflo in E
hilo_writeM, hilo_writeW  in  2  [1]=writes HI, [0]=writes LO
div_startE  in  1  divide enters E this cycle
imem_stall, dmem_stall  in  1  memory wait requests
excepttypeM  in  32  nonzero = exception/ERET in M
cp0_epcM  in  32  EPC
forwardaD, forwardbD  out  2  00 reg, 01 E, 10 M, 11 W
forwardaE, forwardbE  out  2  00 reg, 10 M, 01 W
forward_hiloE  out  2  00 reg, 01 M, 10 W
stallF, stallD, stallE, stallM, stallW  out  1  hold stage register
flushD, flushE, flushM, flushW  out  1  bubble stage register
div_busy  out  1  divider in flight
div_cancel  out  1  one-cycle abort to divider
pc_redirect  out  1  PC must load newpc
newpc  out  32  redirect target (registered)

Behaviour:
- FSM states: RUN, DIV, REDIR. Reset → RUN, counter 0, newpc 0, pc_redirect 0; all stall/flush outputs low while resetn low.
- Forwarding (combinational):
  - Specifier 0 never forwarded.
  - D priority E>M>W. E priority M>W.
  - HI/LO: only the bits requested by hilo_readE are compared, M over W.
- Stall sources:
  - ldstall = (rsD==rtE | rtD==rtE) & rtE!=0 & (memtoregE | cp0_to_regE).
  - brstall = branchD & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})), nonzero specifiers only.
- Priority, highest first: exception > dmem_stall > DIV > imem_stall > ldstall/brstall.
  - exception (excepttypeM!=0, not in REDIR): flushD/E/M=1, stalls 0; newpc <= (excepttypeM==ERET_CODE)? cp0_epcM : EXC_VEC at clock edge; next state REDIR. If state DIV: div_cancel=1 that cycle, counter cleared.
  - dmem_stall: stallF..M=1, flushW=1.
  - DIV: stallF/D/E=1, flushM=1.
  - imem_stall: stallF=1, flushD=1 unless D is also stalled.
  - ld/br stall: stallF/D=1, flushE=1.
- DIV: div_startE in RUN with no exception/dmem_stall → counter=DIV_LAT-1, state DIV; stall applied from the start cycle.
  - Counter decrements each cycle not blocked by dmem_stall.
  - At counter==1 the next edge returns to RUN, so E is released in the cycle after exactly DIV_LAT cycles with the divide in E.
  - div_busy = (state==DIV) | start cycle.
- REDIR: pc_redirect=1, flushD=1. Holds while imem_stall=1, otherwise RUN next cycle. excepttypeM ignored in REDIR (M is already flushed).
- Reset mid-DIV or mid-REDIR: immediate return to RUN, no div_cancel pulse.

Test Plan:
- writeregE=5 regwriteE=1, writeregM=5 regwriteM=1, rsD=5 → forwardaD=01; rsD=0 with writeregE=0 regwriteE=1 → 00.
- memtoregE=1 rtE=8 rsD=8 → stallF=stallD=flushE=1 for one cycle; same with rtE=0 → no stall.
- div_startE=1 with DIV_LAT=4 → stallE high for 4 cycles, low on the 5th cycle; a 2-cycle dmem_stall inside stretches this to 6.
- excepttypeM=1 during DIV → div_cancel=1 and flushD/E/M=1 same cycle; next cycle pc_redirect=1, newpc=BFC00380.
- excepttypeM=0000000E, cp0_epcM=8000_1234, imem_stall high 3 cycles after → pc_redirect held 4 cycles, newpc=80001234, then RUN.
- resetn low asynchronously mid-REDIR → pc_redirect and newpc cleared immediately, no clock needed.
